// File: rtl/halut_decoder_accum.sv
// HALUT decoder: looks up (codebook, prototype) pairs in a writable LUT and sums C terms per row.
// Optional macro HALUT_DECODER_SATURATE_EN clamps the row result instead of wrapping it.

package halut_pkg;
  localparam int K = 16;
  localparam int C = 32;
  localparam int DataTypeWidth = 16;
endpackage

module halut_decoder_accum #(
  parameter int K             = halut_pkg::K,
  parameter int C             = halut_pkg::C,
  parameter int DataTypeWidth = halut_pkg::DataTypeWidth,
  parameter int CAddrWidth    = $clog2(C),
  parameter int TreeDepth     = $clog2(K),
  parameter int LutAddrWidth  = $clog2(C * K),
  parameter int AccWidth      = DataTypeWidth + CAddrWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     decoder_i,
  input  logic [CAddrWidth-1:0]    c_addr_i,
  input  logic [TreeDepth-1:0]     k_addr_i,
  input  logic                     valid_i,
  input  logic [LutAddrWidth-1:0]  waddr_i,
  input  logic [DataTypeWidth-1:0] wdata_i,
  input  logic                     we_i,
  output logic [DataTypeWidth-1:0] result_o,
  output logic                     valid_o,
  output logic                     error_o
);

  logic [DataTypeWidth-1:0] lut [C*K];
  logic [LutAddrWidth-1:0]  raddr;
  logic [DataTypeWidth-1:0] rdata_q;
  logic                     vld_q;
  logic                     first_q;
  logic                     last_q;
  logic [CAddrWidth-1:0]    cnt;
  logic                     cnt_last;
  logic signed [AccWidth-1:0] acc;
  logic signed [AccWidth-1:0] acc_sum;

  assign raddr    = LutAddrWidth'(c_addr_i) * LutAddrWidth'(K) + LutAddrWidth'(k_addr_i);
  assign cnt_last = (cnt == CAddrWidth'(C - 1));

  // NOTE: the LUT is deliberately left out of reset so it maps onto plain RAM and
  // survives both rst_ni and the decoder_i flush.
  always_ff @(posedge clk_i) begin
    if (we_i) lut[waddr_i] <= wdata_i;
  end

  // NOTE: non-blocking write above and registered read here give read-before-write
  // on a same-address collision without any bypass logic.
  always_ff @(posedge clk_i) begin
    rdata_q <= lut[raddr];
  end

  always_comb begin
    acc_sum = (first_q ? '0 : acc)
            + {{CAddrWidth{rdata_q[DataTypeWidth-1]}}, rdata_q};
  end

  function automatic logic [DataTypeWidth-1:0] fmt(input logic signed [AccWidth-1:0] s);
`ifdef HALUT_DECODER_SATURATE_EN
    logic signed [AccWidth-1:0] sat_max;
    logic signed [AccWidth-1:0] sat_min;
    sat_max = {{(AccWidth-DataTypeWidth+1){1'b0}}, {(DataTypeWidth-1){1'b1}}};
    sat_min = {{(AccWidth-DataTypeWidth+1){1'b1}}, {(DataTypeWidth-1){1'b0}}};
    if (s > sat_max)      fmt = sat_max[DataTypeWidth-1:0];
    else if (s < sat_min) fmt = sat_min[DataTypeWidth-1:0];
    else                  fmt = s[DataTypeWidth-1:0];
`else
    fmt = s[DataTypeWidth-1:0];
`endif
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt      <= '0;
      vld_q    <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      acc      <= '0;
      result_o <= '0;
      valid_o  <= 1'b0;
      error_o  <= 1'b0;
    end else if (!decoder_i) begin
      // Flush drops the in-flight term too; result_o keeps its last value.
      cnt     <= '0;
      vld_q   <= 1'b0;
      acc     <= '0;
      valid_o <= 1'b0;
      error_o <= 1'b0;
    end else begin
      vld_q   <= valid_i;
      first_q <= (cnt == '0);
      last_q  <= cnt_last;
      valid_o <= vld_q & last_q;
      if (valid_i) begin
        cnt <= cnt_last ? '0 : cnt + 1'b1;
        if (c_addr_i != cnt) error_o <= 1'b1;
      end
      if (vld_q) begin
        acc <= acc_sum;
        if (last_q) result_o <= fmt(acc_sum);
      end
    end
  end

endmodule

// File: tb/tb_halut_decoder_accum.sv
// Self-checking bench for halut_decoder_accum: row-level reference model plus directed literal checks.
// Build with HALUT_DECODER_SATURATE_EN defined to check the clamping variant.

module tb_halut_decoder_accum;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        decoder_i = 1'b1;
  logic [4:0]  c_addr_i = '0;
  logic [3:0]  k_addr_i = '0;
  logic        valid_i = 1'b0;
  logic [8:0]  waddr_i = '0;
  logic [15:0] wdata_i = '0;
  logic        we_i = 1'b0;
  logic [15:0] result_o;
  logic        valid_o;
  logic        error_o;

  halut_decoder_accum dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .decoder_i (decoder_i),
    .c_addr_i  (c_addr_i),
    .k_addr_i  (k_addr_i),
    .valid_i   (valid_i),
    .waddr_i   (waddr_i),
    .wdata_i   (wdata_i),
    .we_i      (we_i),
    .result_o  (result_o),
    .valid_o   (valid_o),
    .error_o   (error_o)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a row is a list of 32 looked-up terms summed as plain integers.
  int          lut_m [512];
  int          m_cnt = 0;
  longint      m_sum = 0;
  bit          m_err = 0;
  bit          m_pend = 0;
  logic [15:0] m_pend_val = '0;
  bit          m_exp_valid = 0;
  logic [15:0] m_exp_result = '0;
  int          pulse_q [$];

  function automatic logic [15:0] fmt_m(input longint s);
`ifdef HALUT_DECODER_SATURATE_EN
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return s[15:0];
  endfunction

  always @(posedge clk) begin
    if (!rst_ni) begin
      m_cnt = 0; m_sum = 0; m_err = 0; m_pend = 0;
      m_exp_valid = 0; m_exp_result = '0;
    end else if (!decoder_i) begin
      m_cnt = 0; m_sum = 0; m_err = 0; m_pend = 0;
      m_exp_valid = 0;
    end else begin
      m_exp_valid = m_pend;
      if (m_pend) m_exp_result = m_pend_val;
      m_pend = 0;
      if (valid_i) begin
        if (int'(c_addr_i) != m_cnt) m_err = 1;
        m_sum += lut_m[int'(c_addr_i) * 16 + int'(k_addr_i)];
        m_cnt++;
        if (m_cnt == 32) begin
          m_pend = 1;
          m_pend_val = fmt_m(m_sum);
          m_sum = 0;
          m_cnt = 0;
        end
      end
    end
    if (we_i) lut_m[waddr_i] = int'($signed(wdata_i));
    #1;
    check("valid_o", 32'(valid_o), 32'(m_exp_valid));
    check("result_o", 32'(result_o), 32'(m_exp_result));
    check("error_o", 32'(error_o), 32'(m_err));
    if (valid_o) pulse_q.push_back(int'(result_o));
  end

  task automatic write(input int a, input logic [15:0] d);
    we_i = 1'b1; waddr_i = 9'(a); wdata_i = d;
    @(negedge clk);
    we_i = 1'b0;
  endtask

  // mode 0: every entry = v; mode 1: entry = its codebook index
  task automatic fill(input int mode, input logic [15:0] v);
    for (int a = 0; a < 512; a++) write(a, (mode == 0) ? v : 16'(a / 16));
  endtask

  task automatic put(input int c, input int k);
    valid_i = 1'b1; c_addr_i = 5'(c); k_addr_i = 4'(k);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic row_diag();
    for (int c = 0; c < 32; c++) put(c, c % 16);
  endtask

  task automatic wait_pulse(input string name, input logic [15:0] exp);
    bit seen = 0;
    int i;
    for (i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid_o) begin seen = 1; break; end
    end
    check({name, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({name, "_latency"}, 32'(i), 32'd0);
      check({name, "_value"}, 32'(result_o), 32'(exp));
    end
  endtask

  initial begin
    idle(2);
    check("reset_result", 32'(result_o), 32'd0);
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_error", 32'(error_o), 32'd0);
    rst_ni = 1'b1;
    idle(1);

    // All-ones LUT
    fill(0, 16'd1);
    row_diag();
    wait_pulse("all_ones", 16'd32);
    check("all_ones_error", 32'(error_o), 32'd0);

    // Saturation vs wrap
    fill(0, 16'h7FFF);
    row_diag();
`ifdef HALUT_DECODER_SATURATE_EN
    wait_pulse("pos_extreme", 16'h7FFF);
`else
    wait_pulse("pos_extreme", 16'hFFE0);
`endif
    fill(0, 16'h8000);
    row_diag();
`ifdef HALUT_DECODER_SATURATE_EN
    wait_pulse("neg_extreme", 16'h8000);
`else
    wait_pulse("neg_extreme", 16'h0000);
`endif

    // Back-to-back rows, second row with random gaps and random prototypes
    fill(1, 16'd0);
    pulse_q.delete();
    for (int c = 0; c < 32; c++) put(c, 0);
    for (int c = 0; c < 32; c++) begin
      put(c, int'($urandom_range(0, 15)));
      idle(int'($urandom_range(1, 3)));
    end
    idle(4);
    check("b2b_pulses", 32'(pulse_q.size()), 32'd2);
    for (int i = 0; i < pulse_q.size(); i++) check("b2b_value", 32'(pulse_q[i]), 32'd496);

    // Order error: skip codebook 2, still 32 inputs
    fill(0, 16'd1);
    put(0, 0); put(1, 0); put(3, 0);
    check("order_err_set", 32'(error_o), 32'd1);
    for (int c = 4; c < 32; c++) put(c, 0);
    put(0, 0);
    wait_pulse("order_row", 16'd32);
    check("order_err_sticky", 32'(error_o), 32'd1);
    decoder_i = 1'b0; idle(1); decoder_i = 1'b1;
    check("order_err_clear", 32'(error_o), 32'd0);

    // Flush mid-row
    pulse_q.delete();
    for (int c = 0; c < 10; c++) put(c, c);
    decoder_i = 1'b0; idle(1); decoder_i = 1'b1;
    row_diag();
    wait_pulse("flush_row", 16'd32);
    check("flush_pulses", 32'(pulse_q.size()), 32'd1);

    // Reset mid-row keeps LUT, zeroes result
    for (int c = 0; c < 10; c++) put(c, c);
    rst_ni = 1'b0; idle(1); rst_ni = 1'b1;
    check("rst_mid_result", 32'(result_o), 32'd0);
    row_diag();
    wait_pulse("rst_row", 16'd32);

    // Read/write collision on LUT[5][3]
    fill(0, 16'd0);
    write(83, 16'd7);
    for (int c = 0; c < 32; c++) begin
      if (c == 5) begin
        we_i = 1'b1; waddr_i = 9'd83; wdata_i = 16'd9;
      end
      put(c, (c == 5) ? 3 : 0);
      we_i = 1'b0;
    end
    wait_pulse("collide_old", 16'd7);
    for (int c = 0; c < 32; c++) put(c, (c == 5) ? 3 : 0);
    wait_pulse("collide_new", 16'd9);

    // Randomised traffic against the model
    fill(1, 16'd0);
    for (int i = 0; i < 3000; i++) begin
      rst_ni    = ($urandom_range(0, 399) != 0);
      decoder_i = ($urandom_range(0, 59) != 0);
      we_i      = rst_ni && ($urandom_range(0, 9) == 0);
      waddr_i   = 9'($urandom);
      wdata_i   = 16'($urandom);
      valid_i   = ($urandom_range(0, 3) != 0);
      c_addr_i  = ($urandom_range(0, 39) == 0) ? 5'($urandom) : 5'(m_cnt);
      k_addr_i  = 4'($urandom);
      @(negedge clk);
    end
    rst_ni = 1'b1; decoder_i = 1'b1; we_i = 1'b0; valid_i = 1'b0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
